// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one subtractor bit-cell plus a borrow flop,
// operands consumed LSB-first, one bit per clock, bracketed by start/busy/done.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bff_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       cell_s;

  // Full-subtractor bit-cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bin);
    sub_cell = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
  endfunction

  // Current bit through the cell; difference bit enters the partial result at the MSB.
  always_comb begin
    cell_s = sub_cell(ra_q[0], rb_q[0], bff_q);
    res_d  = {cell_s[0], res_q[WIDTH-1:1]};
  end

  // Control FSM, operand shifters and the separately held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bff_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            res_q   <= '0;
            bff_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          ra_q  <= {1'b0, ra_q[WIDTH-1:1]};
          rb_q  <= {1'b0, rb_q[WIDTH-1:1]};
          res_q <= res_d;
          bff_q <= cell_s[1];
          cnt_q <= cnt_q + ONE;
          // The borrow out of the last bit is the unsigned a<b flag.
          if (cnt_q == LAST) begin
            diff_q   <= res_d;
            borrow_q <= cell_s[1];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed vector table, handshake corner sequences and a
// randomized sweep on WIDTH 2/8/16 against an arithmetic reference model.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        st2, st8, st16;
  logic [1:0]  a2, b2, diff2;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        busy2, busy8, busy16, done2, done8, done16, br2, br8, br16;

  int checks = 0;
  int errors = 0;
  int sel    = 8;
  int dc2    = 0;
  int dc8    = 0;
  int dc16   = 0;

  logic        done_m, busy_m, borrow_m;
  logic [31:0] diff_m;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;
  vec_t tbl[6];

  serial_sub #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(br2)
  );
  serial_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(br8)
  );
  serial_sub #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(br16)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      2: begin
        done_m = done2; busy_m = busy2; borrow_m = br2; diff_m = {30'd0, diff2};
      end
      16: begin
        done_m = done16; busy_m = busy16; borrow_m = br16; diff_m = {16'd0, diff16};
      end
      default: begin
        done_m = done8; busy_m = busy8; borrow_m = br8; diff_m = {24'd0, diff8};
      end
    endcase
  end

  always @(negedge clk) begin
    if (done2)  dc2  <= dc2 + 1;
    if (done8)  dc8  <= dc8 + 1;
    if (done16) dc16 <= dc16 + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] ref_sub(input int w, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return {(x < y), ((x - y) & mask)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] x, input logic [31:0] y);
    case (sel)
      2:       begin st2  = s; a2  = x[1:0];  b2  = y[1:0];  end
      16:      begin st16 = s; a16 = x[15:0]; b16 = y[15:0]; end
      default: begin st8  = s; a8  = x[7:0];  b8  = y[7:0];  end
    endcase
  endtask

  function automatic int done_count();
    case (sel)
      2:       return dc2;
      16:      return dc16;
      default: return dc8;
    endcase
  endfunction

  // One full operation on the selected DUT, started in the cycle after the call's first negedge.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expd, input logic expb);
    int w;
    int edges;
    int busy_n;
    w = sel;
    @(negedge clk);
    chk("idle_done", {31'd0, done_m}, 32'd0);
    chk("idle_busy", {31'd0, busy_m}, 32'd0);
    drive(1'b1, x, y);
    @(negedge clk);
    drive(1'b0, $urandom, $urandom);
    edges  = 1;
    busy_n = 0;
    while (!done_m && edges < w + 6) begin
      if (busy_m) busy_n++;
      @(negedge clk);
      edges++;
    end
    chk("latency", edges, w + 1);
    chk("busy_cycles", busy_n, w);
    chk("busy_in_done", {31'd0, busy_m}, 32'd0);
    chk("diff", diff_m, expd);
    chk("borrow", {31'd0, borrow_m}, {31'd0, expb});
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] x, y, mask;
    int          edges, snap, bad;
    int          widths[3];

    tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    tbl[5] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    widths[0] = 2; widths[1] = 8; widths[2] = 16;

    rst = 1'b0;
    st2 = 1'b0; st8 = 1'b0; st16 = 1'b0;
    a2 = '0; b2 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;

    // Asynchronous reset, observed before the first rising edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_diff", {24'd0, diff8}, 32'd0);
    chk("rst_borrow", {31'd0, br8}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_hold", {busy8, done8, br8, 21'd0, diff8}, 32'd0);
    end

    // Directed table, issued back-to-back.
    sel = 8;
    for (int i = 0; i < 6; i++) begin
      do_op({24'd0, tbl[i].a}, {24'd0, tbl[i].b}, {24'd0, tbl[i].d}, tbl[i].br);
    end
    repeat (3) begin
      @(negedge clk);
      chk("result_hold", {br8, 23'd0, diff8}, {tbl[5].br, 23'd0, tbl[5].d});
    end

    // Start pulses during SHIFT and DONE must be ignored.
    @(negedge clk);
    drive(1'b1, 32'h10, 32'h01);
    @(negedge clk);
    drive(1'b0, 32'h33, 32'h77);
    edges = 1;
    while (!done8 && edges < 20) begin
      if (edges == 3) drive(1'b1, 32'hFF, 32'h00);
      else            drive(1'b0, $urandom, $urandom);
      @(negedge clk);
      edges++;
    end
    chk("ign_latency", edges, 9);
    chk("ign_diff", {24'd0, diff8}, 32'h0F);
    chk("ign_borrow", {31'd0, br8}, 32'd0);
    drive(1'b1, 32'hFF, 32'h00);
    @(negedge clk);
    drive(1'b0, 32'h00, 32'h00);
    bad = 0;
    repeat (12) begin
      if (busy8 || done8) bad++;
      @(negedge clk);
    end
    chk("ign_no_restart", bad, 0);
    chk("ign_hold", {24'd0, diff8}, 32'h0F);

    // Reset mid-operation aborts with no done pulse.
    drive(1'b1, 32'hC8, 32'h64);
    @(negedge clk);
    drive(1'b0, 32'h00, 32'h00);
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", {31'd0, busy8}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_diff", {24'd0, diff8}, 32'd0);
    chk("abort_borrow", {31'd0, br8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) bad++;
    end
    chk("abort_no_done", bad, 0);
    do_op(32'h64, 32'hC8, 32'h9C, 1'b1);

    // Randomized sweep against the arithmetic model.
    for (int k = 0; k < 3; k++) begin
      sel  = widths[k];
      mask = (32'd1 << sel) - 32'd1;
      @(negedge clk);
      #1 snap = done_count();
      for (int n = 0; n < 1000; n++) begin
        x = $urandom & mask;
        y = $urandom & mask;
        r = ref_sub(sel, x, y);
        do_op(x, y, r[31:0], r[32]);
      end
      @(negedge clk);
      #1 chk("done_count", done_count() - snap, 1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
